// File: rtl/hash_table.sv
// Shared widths and record types for the hash-table pipeline stages.
package hash_table;

    parameter int unsigned KEY_WIDTH        = 32;
    parameter int unsigned VALUE_WIDTH      = 32;
    parameter int unsigned BUCKET_WIDTH     = 8;
    parameter int unsigned TABLE_ADDR_WIDTH = 10;

    typedef enum logic [1:0] {
        OpSearch = 2'd0,
        OpInsert = 2'd1,
        OpDelete = 2'd2,
        OpNop    = 2'd3
    } ht_opcode_e;

    typedef struct packed {
        logic [KEY_WIDTH-1:0]   key;
        logic [VALUE_WIDTH-1:0] value;
        ht_opcode_e             opcode;
    } ht_command_t;

    typedef struct packed {
        ht_command_t                 cmd;
        logic [BUCKET_WIDTH-1:0]     bucket;
        logic [TABLE_ADDR_WIDTH-1:0] head_ptr;
        logic                        head_ptr_val;
    } ht_pdata_t;

endpackage

// File: rtl/head_ptr_lookup.sv
// Hashes each command key to a bucket, reads that bucket's head pointer from a fixed-latency
// RAM and queues {cmd, bucket, head pointer} in order for the data-table search stage.
module head_ptr_lookup #(
    parameter int unsigned KEY_WIDTH    = hash_table::KEY_WIDTH,
    parameter int unsigned BUCKET_WIDTH = hash_table::BUCKET_WIDTH,
    parameter int unsigned A_WIDTH      = hash_table::TABLE_ADDR_WIDTH,
    parameter int unsigned RD_LATENCY   = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  hash_table::ht_command_t cmd_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    output logic [BUCKET_WIDTH-1:0] head_rd_addr_o,
    output logic                    head_rd_en_o,
    input  logic [A_WIDTH-1:0]      head_rd_ptr_i,
    input  logic                    head_rd_ptr_val_i,
    output hash_table::ht_pdata_t   task_o,
    output logic                    task_valid_o,
    input  logic                    task_ready_i
);

    import hash_table::*;

    localparam int unsigned NumChunks = (KEY_WIDTH + BUCKET_WIDTH - 1) / BUCKET_WIDTH;
    localparam int unsigned PadWidth  = NumChunks * BUCKET_WIDTH;
    localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW      = $clog2(FIFO_DEPTH + 1);

    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);
    localparam logic [CntW:0]   DepthLim = (CntW + 1)'(FIFO_DEPTH);
    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

    typedef struct packed {
        logic                    vld;
        ht_command_t             cmd;
        logic [BUCKET_WIDTH-1:0] bucket;
    } stage_t;

    localparam int unsigned PipeBits = RD_LATENCY * $bits(stage_t);

    logic [PadWidth-1:0]     key_pad;
    logic [BUCKET_WIDTH-1:0] bucket;
    logic                    accept;
    logic                    fifo_wr;
    logic                    fifo_rd;

    stage_t                  stage_in;
    stage_t                  stage_out;
    stage_t [RD_LATENCY-1:0] pipe_q, pipe_d;

    ht_pdata_t               wr_entry;
    ht_pdata_t               mem_q [FIFO_DEPTH];

    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]         inflight_q, inflight_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [CntW:0]           occupancy_d;
    logic                    ready_q, ready_d;

    // Bucket hash: XOR fold of the key in BUCKET_WIDTH chunks, top chunk zero-padded.
    assign key_pad = PadWidth'(cmd_i.key);

    always_comb begin
        bucket = '0;
        for (int i = 0; i < int'(NumChunks); i++) begin
            bucket = bucket ^ key_pad[i*BUCKET_WIDTH +: BUCKET_WIDTH];
        end
    end

    assign accept         = cmd_valid_i & ready_q;
    assign head_rd_en_o   = accept;
    assign head_rd_addr_o = bucket;
    assign cmd_ready_o    = ready_q;

    // Shift pipeline that tracks each read so its cmd meets the RAM data on the same cycle.
    always_comb begin
        stage_in        = '0;
        stage_in.vld    = accept;
        stage_in.cmd    = cmd_i;
        stage_in.bucket = bucket;
    end

    assign pipe_d    = PipeBits'({pipe_q, stage_in});
    assign stage_out = pipe_q[RD_LATENCY-1];
    assign fifo_wr   = stage_out.vld;

    always_comb begin
        wr_entry              = '0;
        wr_entry.cmd          = stage_out.cmd;
        wr_entry.bucket       = stage_out.bucket;
        wr_entry.head_ptr     = head_rd_ptr_i;
        wr_entry.head_ptr_val = head_rd_ptr_val_i;
    end

    assign task_valid_o = (count_q != '0);
    assign task_o       = mem_q[rd_ptr_q];
    assign fifo_rd      = task_valid_o & task_ready_i;

    always_comb begin
        wr_ptr_d = fifo_wr ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = fifo_rd ? rd_ptr_q + PtrOne : rd_ptr_q;
    end

    always_comb begin
        inflight_d = inflight_q;
        if (accept && !fifo_wr) begin
            inflight_d = inflight_q + CntOne;
        end else if (!accept && fifo_wr) begin
            inflight_d = inflight_q - CntOne;
        end

        count_d = count_q;
        if (fifo_wr && !fifo_rd) begin
            count_d = count_q + CntOne;
        end else if (!fifo_wr && fifo_rd) begin
            count_d = count_q - CntOne;
        end
    end

    // Every outstanding RAM read already owns a FIFO slot, so returning data is never dropped.
    always_comb begin
        occupancy_d = {1'b0, inflight_d} + {1'b0, count_d};
        ready_d     = (occupancy_d < DepthLim);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pipe_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            mem_q      <= '{default: '0};
        end else begin
            pipe_q     <= pipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            if (fifo_wr) begin
                mem_q[wr_ptr_q] <= wr_entry;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        fifo_wr |-> ((count_q != DepthCnt) || fifo_rd));

    a_ready_budget: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        ready_q |-> (({1'b0, inflight_q} + {1'b0, count_q}) < DepthLim));

endmodule

// File: tb/tb_head_ptr_lookup.sv
// Directed bench for head_ptr_lookup: head-RAM model, scoreboard queue and negedge task monitor.
module tb_head_ptr_lookup;

    import hash_table::*;

    localparam int unsigned RdLat = 2;
    localparam int unsigned Depth = 4;
    localparam int unsigned AW    = TABLE_ADDR_WIDTH;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    ht_command_t       cmd_i = '0;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic [7:0]        head_rd_addr_o;
    logic              head_rd_en_o;
    logic [AW-1:0]     head_rd_ptr_i;
    logic              head_rd_ptr_val_i;
    ht_pdata_t         task_o;
    logic              task_valid_o;
    logic              task_ready_i = 1'b1;

    int                n_assert = 0;
    int                n_fail = 0;
    int                cyc = 0;
    ht_pdata_t         sb_q [$];
    int                pop_cyc [$];
    ht_pdata_t         mon_exp;

    logic [AW-1:0]            ram_ptr [256];
    logic                     ram_val [256];
    logic [RdLat-1:0][AW-1:0] rp_q = '0;
    logic [RdLat-1:0]         rv_q = '0;

    always #5 clk = ~clk;

    head_ptr_lookup #(
        .KEY_WIDTH    (KEY_WIDTH),
        .BUCKET_WIDTH (BUCKET_WIDTH),
        .A_WIDTH      (AW),
        .RD_LATENCY   (RdLat),
        .FIFO_DEPTH   (Depth)
    ) dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .cmd_i             (cmd_i),
        .cmd_valid_i       (cmd_valid_i),
        .cmd_ready_o       (cmd_ready_o),
        .head_rd_addr_o    (head_rd_addr_o),
        .head_rd_en_o      (head_rd_en_o),
        .head_rd_ptr_i     (head_rd_ptr_i),
        .head_rd_ptr_val_i (head_rd_ptr_val_i),
        .task_o            (task_o),
        .task_valid_o      (task_valid_o),
        .task_ready_i      (task_ready_i)
    );

    // Head RAM: data appears exactly RdLat cycles after the read enable.
    always @(posedge clk) begin
        rp_q <= (RdLat * AW)'({rp_q, head_rd_en_o ? ram_ptr[head_rd_addr_o] : {AW{1'b0}}});
        rv_q <= RdLat'({rv_q, head_rd_en_o & ram_val[head_rd_addr_o]});
    end
    assign head_rd_ptr_i     = rp_q[RdLat-1];
    assign head_rd_ptr_val_i = rv_q[RdLat-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_task(input string tag, input ht_pdata_t obs, input ht_pdata_t exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_bucket(input logic [31:0] k);
        return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24];
    endfunction

    // Pops happen at the next posedge; inputs only change just after posedge.
    always @(negedge clk) begin
        if (rst_n && task_valid_o && task_ready_i) begin
            if (sb_q.size() == 0) begin
                chk_bit("unexpected_task", task_valid_o, 1'b0);
            end else begin
                mon_exp = sb_q.pop_front();
                chk_task("task_data", task_o, mon_exp);
                pop_cyc.push_back(cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] key, input logic [31:0] value, input ht_opcode_e op,
                        input logic exp_acc);
        ht_command_t c;
        ht_pdata_t   e;
        c.key       = key;
        c.value     = value;
        c.opcode    = op;
        cmd_i       = c;
        cmd_valid_i = 1'b1;
        @(negedge clk);
        chk_bit("cmd_ready", cmd_ready_o, exp_acc);
        chk_bit("rd_en", head_rd_en_o, exp_acc);
        if (exp_acc) begin
            chk_int("rd_addr", int'(head_rd_addr_o), int'(exp_bucket(key)));
            e.cmd          = c;
            e.bucket       = exp_bucket(key);
            e.head_ptr     = ram_ptr[e.bucket];
            e.head_ptr_val = ram_val[e.bucket];
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_task(output int lat);
        lat = 1;
        while (!task_valid_o && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk_bit("task_valid_timeout", task_valid_o, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while ((task_valid_o || sb_q.size() != 0) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk_bit("drain_valid", task_valid_o, 1'b0);
        chk_int("drain_left", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int b = 0; b < 256; b++) begin
            ram_ptr[b[7:0]] = AW'(b * 37 + 11);
            ram_val[b[7:0]] = (b % 3 != 0);
        end
        ram_ptr[8'h05] = AW'(12'h012);
        ram_val[8'h05] = 1'b1;
        ram_ptr[8'h33] = AW'(12'h2AB);
        ram_val[8'h33] = 1'b0;

        // Reset state and first-ready timing.
        #1 rst_n = 1'b0;
        step(2);
        @(negedge clk);
        chk_bit("rst_ready", cmd_ready_o, 1'b0);
        chk_bit("rst_rd_en", head_rd_en_o, 1'b0);
        chk_bit("rst_task_valid", task_valid_o, 1'b0);
        chk_task("rst_task", task_o, '0);
        rst_n = 1'b1;
        #1 chk_bit("ready_pre_edge", cmd_ready_o, 1'b0);
        @(posedge clk);
        #1 chk_bit("ready_post_edge", cmd_ready_o, 1'b1);
        chk_bit("rd_en_idle", head_rd_en_o, 1'b0);

        // Single command to bucket 5.
        send(32'h0000_0005, 32'h0000_CAFE, OpSearch, 1'b1);
        wait_task(lat);
        chk_int("single_latency", lat, int'(RdLat) + 1);
        chk_int("single_bucket", int'(task_o.bucket), 5);
        chk_int("single_ptr", int'(task_o.head_ptr), 'h12);
        chk_bit("single_val", task_o.head_ptr_val, 1'b1);
        drain();

        // Empty bucket is forwarded, not filtered.
        send(32'h3300_0000, 32'h0BAD_F00D, OpDelete, 1'b1);
        wait_task(lat);
        chk_bit("empty_val", task_o.head_ptr_val, 1'b0);
        chk_int("empty_bucket", int'(task_o.bucket), 'h33);
        chk_int("empty_key", int'(task_o.cmd.key), 32'h3300_0000);
        drain();

        // Back-pressure: only Depth of 8 offered commands are taken.
        task_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(32'hDEAD_0000 + 32'(i) * 32'h0103_0507, 32'(i), OpInsert, (i < int'(Depth)));
        end
        step(4);
        chk_bit("bp_ready_low", cmd_ready_o, 1'b0);
        chk_bit("bp_task_valid", task_valid_o, 1'b1);
        pop_cyc.delete();
        task_ready_i = 1'b1;
        drain();
        chk_int("bp_popped", pop_cyc.size(), int'(Depth));
        step(1);
        chk_bit("bp_ready_back", cmd_ready_o, 1'b1);

        // Streaming: one task per cycle.
        pop_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            send($urandom, $urandom, OpSearch, 1'b1);
        end
        drain();
        chk_int("stream_count", pop_cyc.size(), 16);
        if (pop_cyc.size() == 16) begin
            for (int i = 1; i < 16; i++) begin
                chk_int("stream_consecutive", pop_cyc[i] - pop_cyc[i-1], 1);
            end
        end

        // Simultaneous write and pop with three buffered and one in flight.
        pop_cyc.delete();
        task_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(32'h1000_0000 + 32'(i), 32'(100 + i), OpSearch, 1'b1);
        end
        step(int'(RdLat) + 2);
        chk_bit("wp_ready_at3", cmd_ready_o, 1'b1);
        send(32'h2000_0001, 32'd200, OpInsert, 1'b1);
        chk_bit("wp_ready_full", cmd_ready_o, 1'b0);
        step(int'(RdLat) - 1);
        task_ready_i = 1'b1;
        @(negedge clk);
        chk_bit("wp_ready_during", cmd_ready_o, 1'b0);
        @(posedge clk);
        #1 task_ready_i = 1'b0;
        chk_bit("wp_ready_after", cmd_ready_o, 1'b1);
        send(32'h2000_0002, 32'd201, OpSearch, 1'b1);
        send(32'h2000_0003, 32'd202, OpSearch, 1'b0);
        send(32'h2000_0004, 32'd203, OpSearch, 1'b0);
        task_ready_i = 1'b1;
        drain();
        chk_int("wp_total", pop_cyc.size(), 5);

        // Reset with two buffered and two in flight.
        task_ready_i = 1'b0;
        send(32'h4400_0001, 32'd1, OpSearch, 1'b1);
        send(32'h4400_0002, 32'd2, OpSearch, 1'b1);
        step(int'(RdLat) + 2);
        send(32'h4400_0003, 32'd3, OpSearch, 1'b1);
        send(32'h4400_0004, 32'd4, OpSearch, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_bit("mid_rst_task_valid", task_valid_o, 1'b0);
        chk_bit("mid_rst_ready", cmd_ready_o, 1'b0);
        chk_bit("mid_rst_rd_en", head_rd_en_o, 1'b0);
        chk_task("mid_rst_task", task_o, '0);
        sb_q.delete();
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 task_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_bit("no_task_after_rst", task_valid_o, 1'b0);
        end
        @(posedge clk);
        #1;

        // Normal operation resumes after reset.
        send(32'h0102_0304, 32'h5555_AAAA, OpInsert, 1'b1);
        wait_task(lat);
        chk_int("recover_bucket", int'(task_o.bucket), 4);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/head_ptr_lookup.md
HEAD_PTR_LOOKUP -- requirements
Module: head_ptr_lookup

Interface
REQ-001 SHALL have parameter KEY_WIDTH, default hash_table::KEY_WIDTH, meaning command key width in bits.
REQ-002 SHALL have parameter BUCKET_WIDTH, default hash_table::BUCKET_WIDTH, meaning head-table index width (2^BUCKET_WIDTH buckets).
REQ-003 SHALL have parameter A_WIDTH, default hash_table::TABLE_ADDR_WIDTH, meaning data-table pointer width.
REQ-004 SHALL have parameter RD_LATENCY, default 2, meaning fixed head-RAM read latency in cycles (legal 1..4).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning output buffer entries (power of two, at least RD_LATENCY+1).
REQ-006 Ports, in order: clk_i in 1 clock; rst_n_i in 1 asynchronous active-low reset; one clock, reset asynchronous assert, active-low.
REQ-007 cmd_i in ht_command_t, incoming command (key, value, opcode); cmd_valid_i in 1; cmd_ready_o out 1.
REQ-008 head_rd_addr_o out BUCKET_WIDTH; head_rd_en_o out 1; head_rd_ptr_i in A_WIDTH; head_rd_ptr_val_i in 1, head RAM data valid exactly RD_LATENCY cycles after head_rd_en_o.
REQ-009 task_o out ht_pdata_t (cmd, bucket, head_ptr, head_ptr_val); task_valid_o out 1; task_ready_i in 1, feeding the downstream data-table search stage.

Function
REQ-010 Bucket SHALL be the XOR of the key sliced LSB-first into BUCKET_WIDTH-bit chunks, last chunk zero-padded.
REQ-011 A command SHALL be accepted when cmd_valid_i and cmd_ready_o are both 1 in the same cycle.
REQ-012 On acceptance head_rd_en_o SHALL be 1 and head_rd_addr_o SHALL equal the bucket in that same cycle (combinational issue); otherwise head_rd_en_o SHALL be 0.
REQ-013 The cmd and bucket SHALL be carried in a RD_LATENCY-deep shift pipeline with a valid bit, aligned with the returning RAM data.
REQ-014 When the pipeline valid bit emerges, {cmd, bucket, head_rd_ptr_i, head_rd_ptr_val_i} SHALL be written into the output FIFO that cycle.
REQ-015 cmd_ready_o SHALL be 1 only when (in-flight count + FIFO occupancy) < FIFO_DEPTH; the FIFO SHALL never overflow and RAM data SHALL never be dropped.
REQ-016 The in-flight counter SHALL increment on acceptance, decrement on FIFO write, and remain unchanged when both occur in the same cycle.
REQ-017 FIFO occupancy SHALL behave the same way for simultaneous write and pop (pop = task_valid_o and task_ready_i).
REQ-018 task_valid_o SHALL be 1 whenever the FIFO is non-empty; task_o SHALL be the head entry, held stable while task_valid_o=1 and task_ready_i=0.
REQ-019 Order SHALL be preserved: tasks leave in acceptance order.
REQ-020 Minimum latency, accept to task_valid_o, SHALL be RD_LATENCY+1 cycles (registered FIFO output); sustained throughput SHALL be one command per cycle when task_ready_i is held 1.
REQ-021 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by the occupancy counter.
REQ-022 A task with head_rd_ptr_val_i=0 SHALL be forwarded unchanged with head_ptr_val=0; no filtering SHALL occur in this block.

Reset
REQ-023 While rst_n_i=0: cmd_ready_o=0, head_rd_en_o=0, task_valid_o=0, task_o=0, and all counters, pointers and pipeline valid bits SHALL be 0.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight and buffered commands; no task SHALL appear after deassertion.
REQ-025 cmd_ready_o SHALL first be 1 in the first clock edge after rst_n_i deasserts.

Verification
REQ-026 Single command: key giving bucket 5, RAM returns ptr 0x12, val 1 -> task_valid_o at cycle RD_LATENCY+1 with bucket=5, head_ptr=0x12, head_ptr_val=1.
REQ-027 Back-pressure: task_ready_i=0, issue 8 commands -> exactly FIFO_DEPTH accepted, cmd_ready_o=0 thereafter; release -> all 4 emerge in order, none lost.
REQ-028 Streaming: task_ready_i=1, 16 back-to-back commands -> 16 tasks on 16 consecutive cycles, in order.
REQ-029 Empty bucket: RAM returns val 0 -> task emitted with head_ptr_val=0 and cmd intact.
REQ-030 Reset with 2 in flight and 2 buffered -> task_valid_o=0 immediately; no task emitted after release.
REQ-031 Simultaneous FIFO write and pop at full-minus-one occupancy -> occupancy unchanged, cmd_ready_o stays consistent with REQ-015.
